// File: rtl/raytrace_pkg.sv
// Shared ray-tracing types: Q4.8 fixed-point scalar, raygen FSM states and
// saturating 12-bit add/subtract helpers used by the ray generator.
package raytrace_pkg;

  typedef logic signed [11:0] fixed_t;

  localparam int FRAC_BITS = 8;

  localparam fixed_t FIXED_MAX = 12'sh7FF;  //  2047
  localparam fixed_t FIXED_MIN = 12'sh800;  // -2048

  // 13-bit images of the clamp limits, for comparing the widened true sum.
  localparam logic signed [12:0] SUM_MAX = 13'sh07FF;
  localparam logic signed [12:0] SUM_MIN = 13'sh1800;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } raygen_state_t;

  // Clamp a 13-bit true result into the 12-bit fixed range.
  function automatic fixed_t sat_clamp(input logic signed [12:0] s);
    fixed_t r;
    if (s > SUM_MAX)      r = FIXED_MAX;
    else if (s < SUM_MIN) r = FIXED_MIN;
    else                  r = s[11:0];
    return r;
  endfunction

  function automatic fixed_t sat_add(input fixed_t a, input fixed_t b);
    logic signed [12:0] s;
    s = {a[11], a} + {b[11], b};
    return sat_clamp(s);
  endfunction

  function automatic fixed_t sat_sub(input fixed_t a, input fixed_t b);
    logic signed [12:0] s;
    s = {a[11], a} - {b[11], b};
    return sat_clamp(s);
  endfunction

endpackage

// File: rtl/raygen_axis_stepper.sv
// One direction axis of the ray generator: a registered 12-bit accumulator
// that can be loaded, stepped by a saturating +/- delta, or held.
module raygen_axis_stepper
  import raytrace_pkg::*;
#(
  parameter bit SUBTRACT = 1'b0   // 1: step subtracts delta, 0: step adds it
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  fixed_t load_value,
  input  logic   step,
  input  fixed_t delta,
  output fixed_t value
);

  fixed_t value_reg;
  fixed_t stepped_next;

  // Saturating step result; saturation persists only through the stored value.
  always_comb begin
    stepped_next = SUBTRACT ? sat_sub(value_reg, delta) : sat_add(value_reg, delta);
  end

  // Accumulator: load has priority over step; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_value;
    end else if (step) begin
      value_reg <= stepped_next;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/camera_ray_gen.sv
// Raster-scan primary ray generator. On start it latches the camera origin
// and view-plane stepping constants, then presents one ray per pixel in
// row-major order over a valid/ready handshake (1 ray/clk when unstalled).
// Optional build macro RAYGEN_PIXEL_CENTER_EN offsets the first column and
// first row by half a step so rays pass through pixel centres.
module camera_ray_gen
  import raytrace_pkg::*;
#(
  parameter int H_RES = 16,
  parameter int V_RES = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [11:0]         camX,
  input  logic signed [11:0]         camY,
  input  logic signed [11:0]         camZ,
  input  logic signed [11:0]         xStart,
  input  logic signed [11:0]         yStart,
  input  logic signed [11:0]         xStep,
  input  logic signed [11:0]         yStep,
  input  logic signed [11:0]         focal,
  input  logic                       readyIn,
  output logic                       validOut,
  output logic signed [11:0]         ox,
  output logic signed [11:0]         oy,
  output logic signed [11:0]         oz,
  output logic signed [11:0]         dx,
  output logic signed [11:0]         dy,
  output logic signed [11:0]         dz,
  output logic [$clog2(H_RES)-1:0]   px,
  output logic [$clog2(V_RES)-1:0]   py,
  output logic                       lastPixel,
  output logic                       busy,
  output logic                       frameDone
);

  localparam int PX_W = $clog2(H_RES);
  localparam int PY_W = $clog2(V_RES);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(H_RES - 1);
  localparam logic [PY_W-1:0] PY_LAST = PY_W'(V_RES - 1);

  raygen_state_t   state_reg;
  fixed_t          ox_reg, oy_reg, oz_reg, dz_reg;
  fixed_t          xreload_reg;
  fixed_t          xstep_reg, ystep_reg;
  logic [PX_W-1:0] px_reg;
  logic [PY_W-1:0] py_reg;
  logic            valid_reg, busy_reg, done_reg;

  fixed_t x_frame_load, y_frame_load;
  logic   frame_load, transfer, at_row_end, at_last;
  logic   x_load, x_step, y_step;
  fixed_t x_load_value;
  fixed_t dx_value, dy_value;

`ifdef RAYGEN_PIXEL_CENTER_EN
  // Start half a step into the first pixel on both axes.
  assign x_frame_load = sat_add(xStart, xStep >>> 1);
  assign y_frame_load = sat_sub(yStart, yStep >>> 1);
`else
  assign x_frame_load = xStart;
  assign y_frame_load = yStart;
`endif

  assign frame_load = (state_reg == IDLE) && start;
  assign transfer   = valid_reg && readyIn;
  assign at_row_end = (px_reg == PX_LAST);
  assign at_last    = at_row_end && (py_reg == PY_LAST);

  assign x_load       = frame_load || (transfer && at_row_end && !at_last);
  assign x_step       = transfer && !at_row_end;
  assign y_step       = transfer && at_row_end && !at_last;
  // Row reloads use the value latched at frame start, never the live input.
  assign x_load_value = frame_load ? x_frame_load : xreload_reg;

  raygen_axis_stepper #(.SUBTRACT(1'b0)) u_x_axis (
    .clk        (clk),
    .rst        (rst),
    .load       (x_load),
    .load_value (x_load_value),
    .step       (x_step),
    .delta      (xstep_reg),
    .value      (dx_value)
  );

  raygen_axis_stepper #(.SUBTRACT(1'b1)) u_y_axis (
    .clk        (clk),
    .rst        (rst),
    .load       (frame_load),
    .load_value (y_frame_load),
    .step       (y_step),
    .delta      (ystep_reg),
    .value      (dy_value)
  );

  // Frame FSM with registered handshake/status outputs and pixel counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ox_reg      <= '0;
      oy_reg      <= '0;
      oz_reg      <= '0;
      dz_reg      <= '0;
      xreload_reg <= '0;
      xstep_reg   <= '0;
      ystep_reg   <= '0;
      px_reg      <= '0;
      py_reg      <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            ox_reg      <= camX;
            oy_reg      <= camY;
            oz_reg      <= camZ;
            dz_reg      <= focal;
            xreload_reg <= x_frame_load;
            xstep_reg   <= xStep;
            ystep_reg   <= yStep;
            px_reg      <= '0;
            py_reg      <= '0;
            valid_reg   <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= EMIT;
          end
        end
        EMIT: begin
          if (transfer) begin
            if (at_last) begin
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else if (at_row_end) begin
              px_reg <= '0;
              py_reg <= py_reg + 1'b1;
            end else begin
              px_reg <= px_reg + 1'b1;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign validOut  = valid_reg;
  assign busy      = busy_reg;
  assign frameDone = done_reg;
  assign ox        = ox_reg;
  assign oy        = oy_reg;
  assign oz        = oz_reg;
  assign dz        = dz_reg;
  assign dx        = dx_value;
  assign dy        = dy_value;
  assign px        = px_reg;
  assign py        = py_reg;
  assign lastPixel = valid_reg && at_last;

endmodule

// File: tb/tb_camera_ray_gen.sv
// Self-checking bench for camera_ray_gen (4x2 frame). Expected rays come from
// a closed-form model: dx = clamp(x0 + col*xStep), dy = clamp(y0 - row*yStep).
module tb_camera_ray_gen;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N = H * V;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic readyIn = 1'b0;
  logic signed [11:0] camX = '0, camY = '0, camZ = '0;
  logic signed [11:0] xStart = '0, yStart = '0, xStep = '0, yStep = '0, focal = '0;
  logic validOut, lastPixel, busy, frameDone;
  logic signed [11:0] ox, oy, oz, dx, dy, dz;
  logic [1:0] px;
  logic [0:0] py;

  int total = 0;
  int bad = 0;

  // Frame configuration used by the reference model.
  int cx, cy, cz, xs, ys, xst, yst, fo;

  camera_ray_gen #(.H_RES(H), .V_RES(V)) dut (
    .clk(clk), .rst(rst), .start(start),
    .camX(camX), .camY(camY), .camZ(camZ),
    .xStart(xStart), .yStart(yStart), .xStep(xStep), .yStep(yStep),
    .focal(focal), .readyIn(readyIn), .validOut(validOut),
    .ox(ox), .oy(oy), .oz(oz), .dx(dx), .dy(dy), .dz(dz),
    .px(px), .py(py), .lastPixel(lastPixel), .busy(busy), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int exp_dx(input int col);
    int x0;
    x0 = xs;
`ifdef RAYGEN_PIXEL_CENTER_EN
    x0 = clampi(xs + (xst >>> 1));
`endif
    return clampi(x0 + col * xst);
  endfunction

  function automatic int exp_dy(input int row);
    int y0;
    y0 = ys;
`ifdef RAYGEN_PIXEL_CENTER_EN
    y0 = clampi(ys - (yst >>> 1));
`endif
    return clampi(y0 - row * yst);
  endfunction

  function automatic int rnd12();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic set_cfg(input int a, input int b, input int c, input int d,
                         input int e, input int f, input int g, input int h);
    cx = a; cy = b; cz = c; xs = d; ys = e; xst = f; yst = g; fo = h;
  endtask

  task automatic scramble_inputs();
    camX = 12'(rnd12()); camY = 12'(rnd12()); camZ = 12'(rnd12());
    xStart = 12'(rnd12()); yStart = 12'(rnd12());
    xStep = 12'(rnd12()); yStep = 12'(rnd12()); focal = 12'(rnd12());
  endtask

  // mode 0: ready always; 1: ready pattern 1,0,0; 2: random ready.
  // start_at / rst_at: transfer index at which to inject start / reset (-1 none).
  task automatic run_frame(input string name, input int mode, input int start_at, input int rst_at);
    int idx, cyc;
    bit rdy, sent;
    idx = 0; cyc = 0; sent = 0;
    camX = 12'(cx); camY = 12'(cy); camZ = 12'(cz);
    xStart = 12'(xs); yStart = 12'(ys); xStep = 12'(xst); yStep = 12'(yst); focal = 12'(fo);
    readyIn = 1'b0;
    chk({name, ".pre_valid"}, int'(validOut), 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    chk({name, ".start_valid"}, int'(validOut), 1);
    while (idx < N && cyc < 200) begin
      chk({name, ".valid"}, int'(validOut), 1);
      chk({name, ".busy"}, int'(busy), 1);
      chk({name, ".frameDone"}, int'(frameDone), 0);
      chk({name, ".px"}, int'(px), idx % H);
      chk({name, ".py"}, int'(py), idx / H);
      chk({name, ".dx"}, int'(dx), exp_dx(idx % H));
      chk({name, ".dy"}, int'(dy), exp_dy(idx / H));
      chk({name, ".ox"}, int'(ox), cx);
      chk({name, ".oy"}, int'(oy), cy);
      chk({name, ".oz"}, int'(oz), cz);
      chk({name, ".dz"}, int'(dz), fo);
      chk({name, ".lastPixel"}, int'(lastPixel), int'(idx == N - 1));
      if (idx == rst_at) begin
        rst = 1'b1;
        #1;
        chk({name, ".rst_valid"}, int'(validOut), 0);
        chk({name, ".rst_busy"}, int'(busy), 0);
        chk({name, ".rst_dx"}, int'(dx), 0);
        chk({name, ".rst_px"}, int'(px), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        readyIn = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          chk({name, ".rst_noDone"}, int'(frameDone), 0);
          chk({name, ".rst_idle_valid"}, int'(validOut), 0);
        end
        $display("%s: reset at transfer %0d", name, idx);
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      readyIn = rdy;
      if (idx == start_at && !sent) begin
        start = 1'b1;
        sent = 1;
      end
      scramble_inputs();
      @(posedge clk); #1;
      start = 1'b0;
      if (rdy) begin
        $display("%s: xfer %0d px=%0d py=%0d dx=%0d dy=%0d", name, idx, idx % H, idx / H,
                 exp_dx(idx % H), exp_dy(idx / H));
        idx++;
      end
      cyc++;
    end
    chk({name, ".transfers"}, idx, N);
    if (mode == 0) chk({name, ".cycles"}, cyc, N);
    chk({name, ".done_pulse"}, int'(frameDone), 1);
    chk({name, ".done_valid"}, int'(validOut), 0);
    chk({name, ".done_busy"}, int'(busy), 0);
    readyIn = 1'b1;
    @(posedge clk); #1;
    chk({name, ".done_clear"}, int'(frameDone), 0);
    chk({name, ".idle_valid"}, int'(validOut), 0);
    @(posedge clk); #1;
    chk({name, ".idle_valid2"}, int'(validOut), 0);
    chk({name, ".idle_done2"}, int'(frameDone), 0);
    readyIn = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset.valid", int'(validOut), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.frameDone", int'(frameDone), 0);
    chk("reset.dx", int'(dx), 0);
    chk("reset.ox", int'(ox), 0);
    chk("reset.px", int'(px), 0);
    // start together with reset: reset wins
    start = 1'b1;
    @(posedge clk); #1;
    chk("reset.start_ignored", int'(validOut), 0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame
    set_cfg(0, 0, -512, -256, 128, 128, 256, 256);
    run_frame("basic", 0, -1, -1);

    // Backpressure
    run_frame("backpressure", 1, -1, -1);

    // Positive and negative saturation
    set_cfg(10, -20, 30, 2000, 100, 100, 50, -7);
    run_frame("sat_pos", 0, -1, -1);
    set_cfg(-1, 1, 2, -2000, -2000, -100, 500, 99);
    run_frame("sat_neg", 2, -1, -1);

    // Start while busy is ignored
    set_cfg(0, 0, -512, -256, 128, 128, 256, 256);
    run_frame("start_busy", 2, 3, -1);

    // Reset mid-frame, then a fresh frame from (0,0)
    run_frame("rst_mid", 0, -1, 5);
    run_frame("after_rst", 0, -1, -1);

    // Random configurations with random backpressure
    for (int f = 0; f < 4; f++) begin
      set_cfg(rnd12(), rnd12(), rnd12(), rnd12(), rnd12(), rnd12(), rnd12(), rnd12());
      run_frame("random", 2, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
